snake_tick_gen: RTL and testbench

Programmable 10-bit modulo counter that produces the periodic game-tick pulse driving snake movement. It is the producing end of the count/max equality check used elsewhere in the design. The block owns the running count and the active maximum, detects count == max internally, wraps, and emits a one-cycle tick. Game control starts, stops and pauses it, and changes the speed by loading a new maximum, which is applied safely at the next wrap.

---
 rtl/snake_tick_gen_if.sv | 27 ++
 rtl/snake_tick_gen.sv | 84 ++++++++
 tb/tb_snake_tick_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/snake_tick_gen_if.sv
// Control and status bundle between game control (master) and the tick generator (slave).
interface snake_tick_gen_if #(
    parameter int WIDTH  = 10,
    parameter int TCNT_W = 16
);
    logic              start;
    logic              stop;
    logic              hold;
    logic              max_load;
    logic [WIDTH-1:0]  max_in;
    logic [WIDTH-1:0]  count;
    logic [WIDTH-1:0]  max_active;
    logic              tick;
    logic [TCNT_W-1:0] tick_cnt;
    logic              running;
    logic              pending;

    modport master (
        output start, stop, hold, max_load, max_in,
        input  count, max_active, tick, tick_cnt, running, pending
    );

    modport slave (
        input  start, stop, hold, max_load, max_in,
        output count, max_active, tick, tick_cnt, running, pending
    );
endinterface

// File: rtl/snake_tick_gen.sv
// Programmable modulo counter emitting the snake game tick; a new period loaded
// while counting is held in a shadow register and applied at the next wrap.
module snake_tick_gen #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] DEFAULT_MAX = 10'd999,
    parameter int               TCNT_W      = 16
) (
    input logic             clk,
    input logic             resetn,
    snake_tick_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [TCNT_W-1:0] TCNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic             wrap;

    // A wrap only counts when stop is not clearing the counter on this edge.
    assign wrap = (state == RUN) && (bus.count == bus.max_active) && !bus.stop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            shadow         <= DEFAULT_MAX;
            bus.count      <= '0;
            bus.max_active <= DEFAULT_MAX;
            bus.tick       <= 1'b0;
            bus.tick_cnt   <= '0;
            bus.running    <= 1'b0;
            bus.pending    <= 1'b0;
        end else begin
            bus.tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.max_load) bus.max_active <= bus.max_in;
                    if (bus.start && !bus.stop) begin
                        state        <= RUN;
                        bus.count    <= '0;
                        bus.tick_cnt <= '0;
                        bus.running  <= 1'b1;
                    end
                end
                RUN, HOLD: begin
                    if (bus.stop) begin
                        state       <= IDLE;
                        bus.count   <= '0;
                        bus.running <= 1'b0;
                        bus.pending <= 1'b0;
                        // Count is forced to 0, so any new maximum is safe to apply now.
                        if (bus.max_load)     bus.max_active <= bus.max_in;
                        else if (bus.pending) bus.max_active <= shadow;
                    end else begin
                        if (state == RUN) begin
                            if (wrap) begin
                                bus.count <= '0;
                                bus.tick  <= 1'b1;
                                if (bus.tick_cnt != TCNT_MAX) bus.tick_cnt <= bus.tick_cnt + 1'b1;
                            end else begin
                                bus.count <= bus.count + 1'b1;
                            end
                            if (bus.hold) state <= HOLD;
                        end else if (!bus.hold) begin
                            state <= RUN;
                        end

                        if (bus.max_load && wrap) begin
                            bus.max_active <= bus.max_in;
                            bus.pending    <= 1'b0;
                        end else if (bus.max_load) begin
                            shadow      <= bus.max_in;
                            bus.pending <= 1'b1;
                        end else if (wrap && bus.pending) begin
                            bus.max_active <= shadow;
                            bus.pending    <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_tick_gen.sv
// Directed checks of snake_tick_gen: periods, deferred/bypassed max loads, hold, stop, saturation, async reset.
module tb_snake_tick_gen;
    logic clk;
    logic resetn;
    int   n_chk;
    int   n_pass;
    int   gap;
    logic seen;

    snake_tick_gen_if #(.WIDTH(10), .TCNT_W(4)) bus ();

    snake_tick_gen #(.WIDTH(10), .DEFAULT_MAX(10'd999), .TCNT_W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
    endtask

    task automatic load(input logic [9:0] v);
        bus.max_load = 1'b1; bus.max_in = v; step(); bus.max_load = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        resetn = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
        bus.max_load = 1'b0; bus.max_in = '0;
        repeat (3) step();
        chk("rst_count",   32'(bus.count), 0);
        chk("rst_tick",    32'(bus.tick), 0);
        chk("rst_tcnt",    32'(bus.tick_cnt), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_max",     32'(bus.max_active), 999);
        resetn = 1'b1;
        step();

        // Period 5 from an IDLE load
        load(10'd4);
        chk("idle_load_max", 32'(bus.max_active), 4);
        chk("idle_load_pend", 32'(bus.pending), 0);
        pulse_start();
        chk("start_count", 32'(bus.count), 0);
        chk("start_running", 32'(bus.running), 1);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("p5_count", 32'(bus.count), 32'(i % 5));
            chk("p5_tick", 32'(bus.tick), (i % 5 == 0) ? 1 : 0);
        end
        chk("p5_tcnt", 32'(bus.tick_cnt), 3);

        // Deferred load while running
        pulse_stop();
        chk("stop_running", 32'(bus.running), 0);
        chk("stop_tcnt_kept", 32'(bus.tick_cnt), 3);
        load(10'd9);
        pulse_start();
        chk("restart_tcnt", 32'(bus.tick_cnt), 0);
        repeat (3) step();
        chk("pre_load_count", 32'(bus.count), 3);
        load(10'd2);
        chk("defer_pending", 32'(bus.pending), 1);
        chk("defer_count", 32'(bus.count), 4);
        chk("defer_max_old", 32'(bus.max_active), 9);
        repeat (5) step();
        chk("defer_reach9", 32'(bus.count), 9);
        step();
        chk("defer_wrap_tick", 32'(bus.tick), 1);
        chk("defer_wrap_max", 32'(bus.max_active), 2);
        chk("defer_wrap_pend", 32'(bus.pending), 0);
        step(); chk("p3_tick_a", 32'(bus.tick), 0);
        step(); chk("p3_tick_b", 32'(bus.tick), 0);
        step(); chk("p3_tick_c", 32'(bus.tick), 1);

        // Load coinciding with the wrap edge
        repeat (2) step();
        chk("bypass_pre", 32'(bus.count), 2);
        load(10'd6);
        chk("bypass_tick", 32'(bus.tick), 1);
        chk("bypass_max", 32'(bus.max_active), 6);
        chk("bypass_pend", 32'(bus.pending), 0);

        // Hold stretches the period
        pulse_stop();
        load(10'd7);
        pulse_start();
        repeat (8) step();
        chk("p8_tick", 32'(bus.tick), 1);
        repeat (4) step();
        chk("hold_pre", 32'(bus.count), 4);
        bus.hold = 1'b1;
        step();
        chk("hold_count0", 32'(bus.count), 5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_count", 32'(bus.count), 5);
            chk("hold_tick", 32'(bus.tick), 0);
            chk("hold_running", 32'(bus.running), 1);
        end
        bus.hold = 1'b0;
        step();
        chk("release_count", 32'(bus.count), 5);
        gap = 9; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            gap++;
            if (bus.tick) seen = 1'b1;
        end
        chk("hold_tick_seen", 32'(seen), 1);
        chk("hold_interval", 32'(gap), 12);

        // start+stop+hold together while running
        chk("tcnt_before_stop", 32'(bus.tick_cnt), 2);
        bus.start = 1'b1; bus.stop = 1'b1; bus.hold = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
        chk("combo_running", 32'(bus.running), 0);
        chk("combo_count", 32'(bus.count), 0);
        chk("combo_tcnt", 32'(bus.tick_cnt), 2);
        pulse_start();
        chk("combo_restart_tcnt", 32'(bus.tick_cnt), 0);

        // max 0: tick every cycle, tick_cnt saturates at 15
        pulse_stop();
        load(10'd0);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("zero_tick", 32'(bus.tick), 1);
            chk("zero_count", 32'(bus.count), 0);
        end
        repeat (17) step();
        chk("sat_tcnt", 32'(bus.tick_cnt), 15);

        // Asynchronous reset between edges
        #3 resetn = 1'b0;
        #1;
        chk("arst_count",   32'(bus.count), 0);
        chk("arst_tick",    32'(bus.tick), 0);
        chk("arst_tcnt",    32'(bus.tick_cnt), 0);
        chk("arst_running", 32'(bus.running), 0);
        chk("arst_pending", 32'(bus.pending), 0);
        chk("arst_max",     32'(bus.max_active), 999);
        resetn = 1'b1;
        repeat (3) step();
        chk("post_rst_count", 32'(bus.count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
